traffic_phase_controller: RTL and testbench

// Sequences a two-road (NS/EW) intersection using the 1 Hz enable pulse from the divider.

---
 rtl/traffic_phase_controller.sv | 134 +++++++++++++
 tb/tb_traffic_phase_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_controller.sv
// Two-road (NS/EW) intersection sequencer driven by a 1 Hz tick.
// Serves EW car demand and latched pedestrian requests; every phase starts on a fresh divider second.
module traffic_phase_controller #(
    parameter int unsigned NS_GREEN_SEC = 10,
    parameter int unsigned EW_GREEN_SEC = 8,
    parameter int unsigned YELLOW_SEC   = 3,
    parameter int unsigned ALLRED_SEC   = 1,
    parameter int unsigned CNT_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Hz1_enable,
    input  logic             ew_car,
    input  logic             ped_req,
    output logic             divider_reset,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic             ped_walk,
    output logic             ped_ack,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] sec_remaining
);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR_A = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR_B = 3'd5
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Raw 3-bit register so the unused codes 6/7 stay representable and recoverable.
    logic [2:0]       state;
    logic [2:0]       state_nx;
    state_t           succ;
    logic [CNT_W-1:0] sec_nx;
    logic             pending_nx, walk_nx, ack_nx, div_nx;
    logic [2:0]       ns_nx, ew_nx;
    logic             ped_pending, tick, rest, enter_ew;

    function automatic logic [CNT_W-1:0] duration(input logic [2:0] s);
        case (s)
            NS_G:       duration = CNT_W'(NS_GREEN_SEC);
            NS_Y, EW_Y: duration = CNT_W'(YELLOW_SEC);
            EW_G:       duration = CNT_W'(EW_GREEN_SEC);
            default:    duration = CNT_W'(ALLRED_SEC);
        endcase
    endfunction

    always_comb begin
        tick     = Hz1_enable && !divider_reset;
        rest     = (state == NS_G) && !ew_car && !ped_pending;
        state_nx = state;
        sec_nx   = sec_remaining;

        case (state)
            NS_G:    succ = NS_Y;
            NS_Y:    succ = AR_A;
            AR_A:    succ = EW_G;
            EW_G:    succ = EW_Y;
            EW_Y:    succ = AR_B;
            default: succ = NS_G;
        endcase

        if (state > AR_B) begin
            state_nx = AR_B;
            sec_nx   = duration(AR_B);
        end else if (tick) begin
            if (sec_remaining > CNT_W'(1)) begin
                sec_nx = sec_remaining - CNT_W'(1);
            end else if (!rest) begin
                state_nx = succ;
                sec_nx   = duration(succ);
            end
        end

        div_nx     = (state_nx != state);
        enter_ew   = (state_nx == EW_G) && (state != EW_G);
        pending_nx = ped_pending;
        ack_nx     = 1'b0;

        // A request arriving on the EW_G entry edge is served directly rather than latched.
        if (enter_ew) begin
            walk_nx    = ped_pending || ped_req;
            pending_nx = 1'b0;
        end else begin
            walk_nx = (state_nx == EW_G) && ped_walk;
            if (ped_req && !ped_pending) begin
                pending_nx = 1'b1;
                ack_nx     = 1'b1;
            end
        end

        ns_nx = RED;
        ew_nx = RED;
        case (state_nx)
            NS_G:    ns_nx = GRN;
            NS_Y:    ns_nx = YEL;
            EW_G:    ew_nx = GRN;
            EW_Y:    ew_nx = YEL;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= AR_B;
            sec_remaining <= CNT_W'(ALLRED_SEC);
            ns_light      <= RED;
            ew_light      <= RED;
            ped_walk      <= 1'b0;
            ped_ack       <= 1'b0;
            ped_pending   <= 1'b0;
            divider_reset <= 1'b1;
        end else begin
            state         <= state_nx;
            sec_remaining <= sec_nx;
            ns_light      <= ns_nx;
            ew_light      <= ew_nx;
            ped_walk      <= walk_nx;
            ped_ack       <= ack_nx;
            ped_pending   <= pending_nx;
            divider_reset <= div_nx;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench for traffic_phase_controller: stimulus pushes model snapshots, a negedge monitor checks them.
module tb_traffic_phase_controller;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset, Hz1_enable, ew_car, ped_req;
    logic             divider_reset, ped_walk, ped_ack;
    logic [2:0]       ns_light, ew_light, phase;
    logic [CNT_W-1:0] sec_remaining;

    always #5 clk = ~clk;

    traffic_phase_controller #(
        .NS_GREEN_SEC(10),
        .EW_GREEN_SEC(8),
        .YELLOW_SEC(3),
        .ALLRED_SEC(1),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Hz1_enable(Hz1_enable),
        .ew_car(ew_car),
        .ped_req(ped_req),
        .divider_reset(divider_reset),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .ped_walk(ped_walk),
        .ped_ack(ped_ack),
        .phase(phase),
        .sec_remaining(sec_remaining)
    );

    typedef struct packed {
        logic [2:0]       ph;
        logic [CNT_W-1:0] sec;
        logic [2:0]       ns;
        logic [2:0]       ew;
        logic             walk;
        logic             ack;
        logic             dr;
    } snap_t;

    snap_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    // Reference model: phase code advances modulo 6, durations come from a table.
    int dur[6] = '{10, 3, 1, 8, 3, 1};
    int m_p    = 5;
    int m_rem  = 1;
    bit m_pend, m_walk, m_ack;
    bit m_dr   = 1'b1;

    function automatic logic [2:0] lamp(input int p, input int green_code);
        if (p == green_code)     return 3'b001;
        if (p == green_code + 1) return 3'b010;
        return 3'b100;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit hz, input bit car, input bit req);
        int    old;
        snap_t s;
        if (r) begin
            m_p = 5; m_rem = dur[5]; m_pend = 0; m_walk = 0; m_ack = 0; m_dr = 1;
        end else begin
            old = m_p;
            if (m_p > 5) begin
                m_p = 5;
                m_rem = dur[5];
            end else if (hz && !m_dr) begin
                if (m_rem > 1) m_rem--;
                else if (!(m_p == 0 && !car && !m_pend)) begin
                    m_p   = (m_p + 1) % 6;
                    m_rem = dur[m_p];
                end
            end
            m_dr  = (m_p != old);
            m_ack = 0;
            if (m_p == 3 && old != 3) begin
                m_walk = m_pend || req;
                m_pend = 0;
            end else begin
                m_walk = m_walk && (m_p == 3);
                if (req && !m_pend) begin
                    m_pend = 1;
                    m_ack  = 1;
                end
            end
        end
        s.ph   = 3'(m_p);
        s.sec  = CNT_W'(m_rem);
        s.ns   = lamp(m_p, 0);
        s.ew   = lamp(m_p, 3);
        s.walk = m_walk;
        s.ack  = m_ack;
        s.dr   = m_dr;
        exp_q.push_back(s);
    endtask

    task automatic cycle(input bit r, input bit car, input bit req);
        Hz1_enable = (cyc % 4 == 0);
        reset      = r;
        ew_car     = car;
        ped_req    = req;
        model_step(r, Hz1_enable, car, req);
        @(negedge clk);
        #1;
        cyc++;
    endtask

    always @(negedge clk) begin
        snap_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {phase, sec_remaining, ns_light, ew_light, ped_walk, ped_ack, divider_reset};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL outputs @%0t: got ph=%0d sec=%0d ns=%b ew=%b walk=%b ack=%b drst=%b, expected ph=%0d sec=%0d ns=%b ew=%b walk=%b ack=%b drst=%b",
                         $time, a.ph, a.sec, a.ns, a.ew, a.walk, a.ack, a.dr,
                         e.ph, e.sec, e.ns, e.ew, e.walk, e.ack, e.dr);
            end
            check("lamps_exclusive", 32'(ns_light != 3'b100 && ew_light != 3'b100), 32'd0);
            check("lamps_onehot", 32'($onehot(ns_light) && $onehot(ew_light)), 32'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        bit car;

        // Reset for 3 clocks
        repeat (3) cycle(1, 0, 0);
        check("reset_phase", 32'(phase), 32'd5);
        check("reset_sec", 32'(sec_remaining), 32'd1);
        check("reset_ns", 32'(ns_light), 32'(3'b100));
        check("reset_ew", 32'(ew_light), 32'(3'b100));
        check("reset_divrst", 32'(divider_reset), 32'd1);

        // Continuous EW demand: full rotations
        repeat (220) cycle(0, 1, 0);

        // No demand: NS green rests at 1, then demand releases it
        repeat (240) cycle(0, 0, 0);
        check("rest_phase", 32'(phase), 32'd0);
        check("rest_sec", 32'(sec_remaining), 32'd1);
        repeat (8) cycle(0, 1, 0);
        check("rest_release_phase", 32'(phase), 32'd1);

        // Pedestrian pulse in NS green rest, then a duplicate pulse
        repeat (200) cycle(0, 0, 0);
        check("ped_setup_phase", 32'(phase), 32'd0);
        cycle(0, 0, 1);
        check("ped_ack_first", 32'(ped_ack), 32'd1);
        cycle(0, 0, 0);
        check("ped_ack_single", 32'(ped_ack), 32'd0);
        cycle(0, 0, 1);
        check("ped_ack_dup", 32'(ped_ack), 32'd0);
        repeat (150) cycle(0, 0, 0);

        // Request arriving on the EW_G entry edge
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            hit = (m_p == 2) && (cyc % 4 == 0) && !m_dr;
            cycle(0, 1, hit);
        end
        check("entry_req_found", 32'(hit), 32'd1);
        check("entry_req_walk", 32'(ped_walk), 32'd1);
        repeat (40) cycle(0, 1, 0);

        // Reset in the middle of EW green
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            hit = (m_p == 3) && (m_rem == 5);
            if (!hit) cycle(0, 1, 0);
        end
        check("mid_ewg_found", 32'(hit), 32'd1);
        cycle(1, 1, 0);
        check("midrst_phase", 32'(phase), 32'd5);
        check("midrst_ns", 32'(ns_light), 32'(3'b100));
        check("midrst_ew", 32'(ew_light), 32'(3'b100));
        check("midrst_walk", 32'(ped_walk), 32'd0);
        check("midrst_divrst", 32'(divider_reset), 32'd1);
        repeat (30) cycle(0, 1, 0);

        // Illegal state code recovery
        force dut.state = 3'd7;
        #1;
        release dut.state;
        m_p = 7;
        cycle(0, 1, 0);
        check("illegal_recover_phase", 32'(phase), 32'd5);
        check("illegal_recover_divrst", 32'(divider_reset), 32'd1);

        // Randomised traffic, pedestrians and occasional reset
        car = 1;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) car = ($urandom_range(0, 2) != 0);
            cycle($urandom_range(0, 249) == 0, car, $urandom_range(0, 24) == 0);
        end

        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
